regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Owns the single write port of the 32x32 register file (`regfile`). It shares that port between two sources:
- the in-order pipeline writeback, which can never be back-pressured;
- the multi-cycle M-extension unit (MDU) result, which uses a valid/ready handshake.

It also keeps a pending-write scoreboard for MDU destinations and drives the decode-stage hazard stall. It sits between the WB stage, the MDU and the regfile write inputs.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles an MDU result may be refused before the arbiter forces a pipeline hold to drain it (legal range 1..15).
- NREG, 32, number of architectural registers; a 5-bit index is implied.

Ports:
- clk  in  1  system clock; all logic acts on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wb_valid  in  1  pipeline writeback request this cycle.
- wb_rd  in  5  pipeline destination register.
- wb_data  in  32  pipeline write data.
- mdu_valid  in  1  MDU result available; held stable until accepted.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- mdu_ready  out  1  MDU result accepted this cycle.
- iss_valid  in  1  an MDU op issues this cycle.
- iss_rd  in  5  destination register of the issuing MDU op.
- dec_rs1  in  5  decode-stage source register 1.
- dec_rs2  in  5  decode-stage source register 2.
- dec_rd  in  5  decode-stage destination register.
- dec_stall  out  1  decode must stall: a RAW or WAW conflict on a pending MDU register.
- pipe_hold  out  1  pipeline must not produce a writeback next cycle (starvation relief).
- rf_we  out  1  to regfile reg_write.
- rf_rd  out  5  to regfile rd.
- rf_wd  out  32  to regfile wd.
- pending  out  32  scoreboard bit vector, for debug and verification.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rf_we=0, rf_rd=0, rf_wd=0.
  - pending=0, starvation counter=0, pipe_hold=0.
  - Reset mid-handshake discards the outstanding MDU result; the MDU is reset by the same signal.
- Arbitration (combinational grant, registered write):
  - If wb_valid=1 and pipe_hold=0: grant the pipeline, and mdu_ready=0.
  - Otherwise, if mdu_valid=1: grant the MDU, and mdu_ready=1.
  - wb_valid=1 while pipe_hold=1 is a protocol violation; the simulation assertion fires and the MDU still wins.
- Write latency: exactly 1 cycle. The granted rd/data are registered into rf_rd/rf_wd, with rf_we=1 in the next cycle.
  - A grant with rd=0 still consumes the slot (mdu_ready=1 for an MDU grant) but registers rf_we=0.
  - No grant: rf_we=0, and rf_rd/rf_wd hold their previous values.
- Scoreboard:
  - Set pending[iss_rd] on iss_valid when iss_rd!=0.
  - Clear pending[mdu_rd] on an MDU accept (mdu_valid & mdu_ready).
  - Set and clear of the same index in the same cycle: set wins.
  - pending[0] is always 0.
  - Only MDU writes are tracked; pipeline writebacks never touch the scoreboard.
- dec_stall (combinational from registered state only; no input-to-output path from mdu_*):
  - dec_stall = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd].
  - Register x0 never stalls.
  - A register being cleared this cycle still stalls this cycle; the stall drops the next cycle. This matches the 1-cycle write latency, so decode never reads a stale regfile value.
- Starvation state machine, states IDLE and STARVE:
  - IDLE: the counter increments each cycle that mdu_valid=1 and mdu_ready=0, and resets to 0 on an MDU accept or when mdu_valid=0.
    - When the counter reaches STARVE_LIMIT: go to STARVE, registered pipe_hold=1.
  - STARVE: pipe_hold=1 for exactly one cycle. The MDU is guaranteed the grant, then the state returns to IDLE with counter=0.
  - Worst-case MDU wait is STARVE_LIMIT+1 cycles.

Decomposition:
- Shared package rv_pkg holds:
  - REG_IDX_W=5, XLEN=32;
  - the arbiter state enum (ARB_IDLE, ARB_STARVE);
  - the grant-source encoding (GNT_NONE, GNT_WB, GNT_MDU).
- One natural sub-module, wb_scoreboard: the pending vector with set/clear/priority logic and the three-port hazard lookup.
- Arbitration, the starvation FSM and the output register stay in the top.

Test Plan:
- Reset behaviour: assert rst_n=0 for 2 cycles with all inputs toggling -> rf_we=0, pending=0, pipe_hold=0, dec_stall=0.
- Solo pipeline write: wb_valid=1, wb_rd=3, wb_data=0x0000_00C8 -> next cycle rf_we=1, rf_rd=3, rf_wd=0xC8; a second pulse with wb_rd=0 -> rf_we=0.
- MDU flow:
  - Issue: iss_valid, iss_rd=5 -> pending[5]=1; dec_rs2=5 -> dec_stall=1.
  - Accept: mdu_valid with mdu_rd=5, mdu_data=0x2710 and no wb -> mdu_ready=1 and pending[5] cleared.
  - Next cycle: rf_we=1, rf_rd=5, rf_wd=0x2710, dec_stall=0.
- Collision: wb_valid and mdu_valid together (wb_rd=3, mdu_rd=5) -> mdu_ready=0 and the WB write goes out first. In the next idle cycle mdu_ready=1, and x5 is written one cycle later.
- Starvation: wb_valid=1 continuously, mdu_valid=1, STARVE_LIMIT=4 -> pipe_hold=1 in cycle 5, mdu_ready=1 in that cycle, counter back to 0.
- Simultaneous set/clear: iss_rd=7 issues in the same cycle an MDU result for rd=7 is accepted -> pending[7] remains 1; another issue to rd=0 -> pending unchanged.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types for the regfile write-port arbiter: index/data widths, arbiter states, grant sources.
// Pure declarations; no latency or backpressure of its own.
package rv_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef enum logic {
    ARB_IDLE,
    ARB_STARVE
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_MDU
  } gnt_src_t;

  // One-hot register mask with x0 forced out, so x0 can never be marked pending.
  function automatic logic [31:0] reg_mask(input logic en, input logic [REG_IDX_W-1:0] idx);
    logic [31:0] m;
    m = '0;
    if (en && (idx != '0)) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for MDU destinations with a three-port decode hazard lookup.
// Set/clear take effect the next cycle; the lookup reads registered state only, so no backpressure.
module wb_scoreboard
  import rv_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  output logic [NREG-1:0]      pending,
  output logic                 stall
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  assign set_mask = NREG'(reg_mask(set_en, set_idx));
  assign clr_mask = NREG'(reg_mask(clr_en, clr_idx));

  // Applying the set after the clear makes a same-cycle issue win over a retiring result.
  always_comb begin
    pend_d    = (pend_q & ~clr_mask) | set_mask;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A register retiring this cycle still stalls: its value reaches the regfile one cycle later.
  assign stall   = pend_q[rs1] | pend_q[rs2] | pend_q[rd];
  assign pending = pend_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between the pipeline writeback (never stalled) and the MDU (valid/ready).
// Write lands 1 cycle after grant; MDU waits at most STARVE_LIMIT+1 cycles via a one-cycle pipe_hold.
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NREG         = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        dec_stall,
  output logic        pipe_hold,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic [31:0] pending
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state_q;
  arb_state_t state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  gnt_src_t   gnt;
  logic       mdu_refused;

  // Grant: the pipeline wins unless it is being held off for starvation relief.
  always_comb begin
    gnt = GNT_NONE;
    if (wb_valid && !pipe_hold) begin
      gnt = GNT_WB;
    end else if (mdu_valid) begin
      gnt = GNT_MDU;
    end
  end

  assign mdu_ready   = (gnt == GNT_MDU);
  assign mdu_refused = mdu_valid && !mdu_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (mdu_refused) begin
          if (cnt_q == LIMIT - 4'd1) begin
            state_d = ARB_STARVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ARB_STARVE: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pipe_hold = (state_q == ARB_STARVE);
  end

  // rd=0 grants still consume the slot but never assert the regfile write enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else begin
      case (gnt)
        GNT_WB: begin
          rf_we <= (wb_rd != 5'd0);
          rf_rd <= wb_rd;
          rf_wd <= wb_data;
        end
        GNT_MDU: begin
          rf_we <= (mdu_rd != 5'd0);
          rf_rd <= mdu_rd;
          rf_wd <= mdu_data;
        end
        default: begin
          rf_we <= 1'b0;
        end
      endcase
    end
  end

  logic [NREG-1:0] sb_pending;

  wb_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (iss_valid),
    .set_idx (iss_rd),
    .clr_en  (mdu_ready),
    .clr_idx (mdu_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .rd      (dec_rd),
    .pending (sb_pending),
    .stall   (dec_stall)
  );

  assign pending = 32'(sb_pending);

  a_no_wb_during_hold : assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_valid && pipe_hold));

  a_x0_never_pending : assert property (@(posedge clk) disable iff (!rst_n)
    !pending[0]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference model predicts grants, writes and pending bits.
module tb_regfile_wb_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_stall;
  logic        pipe_hold;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [31:0] pending;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .NREG        (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .mdu_valid(mdu_valid),
    .mdu_rd   (mdu_rd),
    .mdu_data (mdu_data),
    .mdu_ready(mdu_ready),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .dec_rs1  (dec_rs1),
    .dec_rs2  (dec_rs2),
    .dec_rd   (dec_rd),
    .dec_stall(dec_stall),
    .pipe_hold(pipe_hold),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_wd    (rf_wd),
    .pending  (pending)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] m_pend;
  int          m_cnt;
  logic        m_hold;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        last_gm;
  logic        obs_hold;
  logic [31:0] pend_snap;
  int          hold_cyc;
  int          accept_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_cnt   = 0;
    m_hold  = 1'b0;
    m_rd    = '0;
    m_wd    = '0;
    last_gm = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    mdu_valid = 1'b0;
    mdu_rd    = '0;
    mdu_data  = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    dec_rs1   = '0;
    dec_rs2   = '0;
    dec_rd    = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, predict the write, check it after the edge.
  task automatic run_cycle();
    logic        gw;
    logic        gm;
    logic [31:0] setm;
    logic [31:0] clrm;
    wr_t         e;
    @(negedge clk);
    gw = wb_valid && !m_hold;
    gm = !gw && mdu_valid;
    obs_hold = pipe_hold;
    check("mdu_ready", 32'(mdu_ready), 32'(gm));
    check("pipe_hold", 32'(pipe_hold), 32'(m_hold));
    check("dec_stall", 32'(dec_stall), 32'(m_pend[dec_rs1] | m_pend[dec_rs2] | m_pend[dec_rd]));
    if (gw) begin
      m_rd = wb_rd;
      m_wd = wb_data;
    end else if (gm) begin
      m_rd = mdu_rd;
      m_wd = mdu_data;
    end
    e.we = (gw || gm) && (m_rd != 5'd0);
    e.rd = m_rd;
    e.wd = m_wd;
    exp_q.push_back(e);
    setm = '0;
    clrm = '0;
    if (iss_valid && iss_rd != 5'd0) setm[iss_rd] = 1'b1;
    if (gm) clrm[mdu_rd] = 1'b1;
    m_pend    = (m_pend & ~clrm) | setm;
    m_pend[0] = 1'b0;
    if (m_hold) begin
      m_hold = 1'b0;
      m_cnt  = 0;
    end else if (mdu_valid && !gm) begin
      m_cnt++;
      if (m_cnt == STARVE_LIMIT) begin
        m_hold = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      m_cnt = 0;
    end
    last_gm = gm;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rf_we", 32'(rf_we), 32'(e.we));
    check("rf_rd", 32'(rf_rd), 32'(e.rd));
    check("rf_wd", rf_wd, e.wd);
    check("pending", pending, m_pend);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // Reset with inputs toggling.
    for (int i = 0; i < 2; i++) begin
      wb_valid  = 1'($urandom_range(0, 1));
      wb_rd     = 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      mdu_valid = 1'($urandom_range(0, 1));
      mdu_rd    = 5'($urandom_range(0, 31));
      mdu_data  = $urandom;
      iss_valid = 1'b1;
      iss_rd    = 5'($urandom_range(1, 31));
      dec_rs1   = 5'($urandom_range(0, 31));
      dec_rs2   = 5'($urandom_range(0, 31));
      dec_rd    = 5'($urandom_range(0, 31));
      @(posedge clk);
      #1;
    end
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_rd", 32'(rf_rd), 32'd0);
    check("rst_rf_wd", rf_wd, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_pipe_hold", 32'(pipe_hold), 32'd0);
    check("rst_dec_stall", 32'(dec_stall), 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    model_reset();

    // Solo pipeline writes, including x0.
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_00C8;
    run_cycle();
    check("solo_rf_wd", rf_wd, 32'h0000_00C8);
    wb_rd = 5'd0; wb_data = 32'h0000_0055;
    run_cycle();
    check("solo_x0_we", 32'(rf_we), 32'd0);
    idle_inputs();
    run_cycle();

    // MDU issue, hazard, accept.
    iss_valid = 1'b1; iss_rd = 5'd5;
    run_cycle();
    check("issue_pend5", 32'(pending[5]), 32'd1);
    idle_inputs();
    dec_rs2 = 5'd5;
    run_cycle();
    mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h0000_2710;
    run_cycle();
    check("accept_rf_wd", rf_wd, 32'h0000_2710);
    check("accept_pend5", 32'(pending[5]), 32'd0);
    idle_inputs();
    dec_rs2 = 5'd5;
    run_cycle();

    // Collision: pipeline first, MDU in the next idle cycle.
    idle_inputs();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0011;
    mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h0000_2711;
    run_cycle();
    check("coll_wb_rd", 32'(rf_rd), 32'd3);
    wb_valid = 1'b0;
    run_cycle();
    check("coll_mdu_rd", 32'(rf_rd), 32'd5);
    idle_inputs();
    run_cycle();

    // Starvation under continuous pipeline writeback.
    hold_cyc   = 0;
    accept_cyc = 0;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h0000_BEEF;
    for (int c = 1; c <= 8; c++) begin
      wb_valid = !m_hold;
      wb_rd    = 5'(10 + c);
      wb_data  = 32'(c * 7);
      run_cycle();
      if (obs_hold && hold_cyc == 0) hold_cyc = c;
      if (last_gm && accept_cyc == 0) begin
        accept_cyc = c;
        mdu_valid  = 1'b0;
      end
    end
    check("starve_hold_cycle", 32'(hold_cyc), 32'd5);
    check("starve_accept_cycle", 32'(accept_cyc), 32'd5);
    idle_inputs();
    run_cycle();

    // Same-cycle set and clear of x7, then an x0 issue.
    iss_valid = 1'b1; iss_rd = 5'd7;
    run_cycle();
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h0000_0777;
    run_cycle();
    check("setclr_pend7", 32'(pending[7]), 32'd1);
    idle_inputs();
    pend_snap = pending;
    iss_valid = 1'b1; iss_rd = 5'd0;
    run_cycle();
    check("iss_x0_unchanged", pending, pend_snap);
    idle_inputs();
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h0000_0778;
    run_cycle();
    idle_inputs();

    // Reset while an MDU result is outstanding and the pipeline is refusing it.
    iss_valid = 1'b1; iss_rd = 5'd12;
    run_cycle();
    iss_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_0044;
    mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'h0000_0C0C;
    run_cycle();
    run_cycle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_pending", pending, 32'd0);
    check("midrst_rf_we", 32'(rf_we), 32'd0);
    check("midrst_pipe_hold", 32'(pipe_hold), 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    run_cycle();

    // Random traffic obeying the protocol: MDU result held until accepted, no wb during hold.
    for (int i = 0; i < 400; i++) begin
      if (!mdu_valid) begin
        mdu_valid = ($urandom_range(0, 2) == 0);
        mdu_rd    = 5'($urandom_range(0, 15));
        mdu_data  = $urandom;
      end
      wb_valid  = !m_hold && ($urandom_range(0, 3) != 0);
      wb_rd     = 5'($urandom_range(0, 15));
      wb_data   = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 15));
      dec_rs1   = 5'($urandom_range(0, 15));
      dec_rs2   = 5'($urandom_range(0, 15));
      dec_rd    = 5'($urandom_range(0, 15));
      run_cycle();
      if (last_gm) mdu_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
